// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b memory interface.
package lc3b_pkg;

  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEFAULT_MEM_LATENCY = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

endpackage

// File: rtl/mem_latency_counter.sv
// Memory latency countdown: load, decrement, registered zero flag.
module mem_latency_counter
  import lc3b_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  // Neither load nor decrement returns the count to 0, which holds it at 0 in IDLE.
  always_comb begin
    count_d = '0;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_q) begin
      count_d = count_q - CNT_W'(1);
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR register pair and memory access sequencer with fixed read/write latency.
module mem_interface
  import lc3b_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int unsigned WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic             data_size,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_we,
  output logic             mem_mdrControl,
  output logic [WIDTH-1:0] mar,
  output logic [WIDTH-1:0] mdr,
  output logic             r,
  output logic             busy,
  output logic             unaligned
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             rw_q, rw_d;
  logic             ds_q, ds_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [WIDTH-1:0] rd_data;

  mem_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT_M1),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign rd_data = (ds_q == SIZE_WORD) ? mem_dout
                                       : {{(WIDTH-8){mem_dout[7]}}, mem_dout[7:0]};

  // Next-state, register loads and the combinational handshake outputs.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    rw_d      = rw_q;
    ds_d      = ds_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    r         = 1'b0;
    unaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus;
        if (ld_mdr) mdr_d = bus;
        // A same-cycle MAR load defers the access so it sees the new address.
        if (mio_en && !ld_mar) begin
          if (data_size == SIZE_WORD && mar_q[0]) begin
            unaligned = 1'b1;
          end else begin
            cnt_load = 1'b1;
            rw_d     = r_w;
            ds_d     = data_size;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (!mio_en) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          r       = 1'b1;
          state_d = IDLE;
          if (rw_q == ACC_READ) mdr_d = rd_data;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= 1'b0;
      ds_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      ds_q    <= ds_d;
    end
  end

  assign busy           = (state_q == BUSY);
  assign mem_we         = r & rw_q;
  assign mem_mdrControl = busy ? ds_q : data_size;
  assign mar            = mar_q;
  assign mdr            = mdr_q;
  assign mem_addr       = mar_q;
  assign mem_din        = mdr_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: default latency plus a MEM_LATENCY=1 instance.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus = '0;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, data_size = 1'b0;
  logic [15:0] mem_dout = '0;

  logic [15:0] mem_addr, mem_din, mar, mdr;
  logic        mem_we, mem_mdrControl, r, busy, unaligned;
  logic [15:0] mem_addr1, mem_din1, mar1, mdr1;
  logic        mem_we1, mem_mdrControl1, r1, busy1, unaligned1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mem_interface #(.MEM_LATENCY(4), .WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .data_size(data_size), .mem_dout(mem_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_mdrControl(mem_mdrControl), .mar(mar), .mdr(mdr), .r(r),
    .busy(busy), .unaligned(unaligned)
  );

  mem_interface #(.MEM_LATENCY(1), .WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .data_size(data_size), .mem_dout(mem_dout),
    .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_we(mem_we1),
    .mem_mdrControl(mem_mdrControl1), .mar(mar1), .mdr(mdr1), .r(r1),
    .busy(busy1), .unaligned(unaligned1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input logic to_mar, input logic [15:0] v);
    bus    = v;
    ld_mar = to_mar;
    ld_mdr = !to_mar;
    cyc();
    ld_mar = 1'b0;
    ld_mdr = 1'b0;
  endtask

  // Full access with mio_en held: r (and mem_we for writes) only in cycle 4.
  task automatic run_access(input string tag, input logic rw, input logic ds,
                            input logic [15:0] dout);
    r_w       = rw;
    data_size = ds;
    mem_dout  = dout;
    mio_en    = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) cyc();
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_r"}, 32'(r), 32'(k == 4));
      check({tag, "_we"}, 32'(mem_we), 32'(rw && (k == 4)));
      check({tag, "_size"}, 32'(mem_mdrControl), 32'(ds));
    end
    cyc();
    mio_en = 1'b0;
    r_w    = 1'b0;
    #1;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_r_after"}, 32'(r), 32'd0);
  endtask

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mar", 32'(mar), 32'h0);
    check("rst_mdr", 32'(mdr), 32'h0);
    check("rst_r", 32'(r), 32'd0);

    // Word read
    load_reg(1'b1, 16'h0028);
    check("ld_mar", 32'(mar), 32'h0028);
    check("mem_addr", 32'(mem_addr), 32'h0028);
    run_access("wrd", 1'b0, 1'b1, 16'hF0F0);
    check("wrd_mdr", 32'(mdr), 32'hF0F0);

    // Byte reads at an odd address, negative and positive
    load_reg(1'b1, 16'h002B);
    run_access("bneg", 1'b0, 1'b0, 16'hAB94);
    check("bneg_mdr", 32'(mdr), 32'hFF94);
    run_access("bpos", 1'b0, 1'b0, 16'h5514);
    check("bpos_mdr", 32'(mdr), 32'h0014);

    // Word write
    load_reg(1'b0, 16'h1234);
    load_reg(1'b1, 16'h0030);
    check("wr_din", 32'(mem_din), 32'h1234);
    run_access("wr", 1'b1, 1'b1, 16'hDEAD);
    check("wr_mdr_kept", 32'(mdr), 32'h1234);
    check("wr_addr", 32'(mem_addr), 32'h0030);

    // Misaligned word access
    load_reg(1'b1, 16'h0031);
    r_w = 1'b0; data_size = 1'b1; mio_en = 1'b1;
    #1;
    check("ua_pulse", 32'(unaligned), 32'd1);
    check("ua_busy", 32'(busy), 32'd0);
    check("ua_r", 32'(r), 32'd0);
    check("ua_we", 32'(mem_we), 32'd0);
    cyc();
    mio_en = 1'b0;
    #1;
    check("ua_stay_idle", 32'(busy), 32'd0);
    check("ua_clear", 32'(unaligned), 32'd0);

    // ld_mar with mio_en defers start; loads ignored while busy; mio_en drop aborts
    bus = 16'h0040; ld_mar = 1'b1; mio_en = 1'b1; mem_dout = 16'h7777;
    cyc();
    check("ldm_nostart", 32'(busy), 32'd0);
    check("ldm_mar", 32'(mar), 32'h0040);
    ld_mar = 1'b0;
    cyc();
    check("ab_busy", 32'(busy), 32'd1);
    bus = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1;
    cyc();
    check("bsy_mar", 32'(mar), 32'h0040);
    check("bsy_mdr", 32'(mdr), 32'h1234);
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    #1;
    check("ab_r", 32'(r), 32'd0);
    cyc();
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_mdr", 32'(mdr), 32'h1234);

    // Reset at cycle 3 of a write
    r_w = 1'b1; data_size = 1'b1; mio_en = 1'b1;
    cyc();
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) cyc();
      check("rs_we", 32'(mem_we), 32'd0);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    #1;
    check("rs_idle", 32'(busy), 32'd0);
    check("rs_r", 32'(r), 32'd0);
    check("rs_ua", 32'(unaligned), 32'd0);
    check("rs_we_after", 32'(mem_we), 32'd0);
    check("rs_mar", 32'(mar), 32'h0);
    check("rs_mdr", 32'(mdr), 32'h0);
    check("rs1_mar", 32'(mar1), 32'h0);
    cyc();
    check("rs_we_next", 32'(mem_we), 32'd0);

    // MEM_LATENCY=1: r in the first cycle after start
    r_w = 1'b0; data_size = 1'b1; mem_dout = 16'h0BEE; mio_en = 1'b1;
    cyc();
    check("l1_busy", 32'(busy1), 32'd1);
    check("l1_r", 32'(r1), 32'd1);
    check("l1_we", 32'(mem_we1), 32'd0);
    check("l1_size", 32'(mem_mdrControl1), 32'd1);
    cyc();
    mio_en = 1'b0;
    #1;
    check("l1_idle", 32'(busy1), 32'd0);
    check("l1_mdr", 32'(mdr1), 32'h0BEE);
    check("l1_din", 32'(mem_din1), 32'h0BEE);
    check("l1_addr", 32'(mem_addr1), 32'h0);
    check("l1_mar", 32'(mar1), 32'h0);
    check("l1_ua", 32'(unaligned1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 4, meaning the number of cycles from access start to the R cycle, legal range 1..15.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the datapath and address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port bus, input, WIDTH bits: datapath bus value for MAR/MDR loads.
REQ-006 The block SHALL have ports ld_mar, ld_mdr, input, 1 bit each: register load enables from control.
REQ-007 The block SHALL have port mio_en, input, 1 bit: request a memory access.
REQ-008 The block SHALL have port r_w, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port data_size, input, 1 bit: 1 = word, 0 = byte.
REQ-010 The block SHALL have port mem_dout, input, WIDTH bits: read data from memory; the byte at mem_addr is on [7:0].
REQ-011 The block SHALL have ports mem_addr, mem_din, output, WIDTH bits each: equal to MAR and MDR respectively.
REQ-012 The block SHALL have ports mem_we and mem_mdrControl, output, 1 bit each: memory write enable, and word (1) or byte (0) select.
REQ-013 The block SHALL have ports mar, mdr, output, WIDTH bits each: register contents driven to the datapath.
REQ-014 The block SHALL have ports r, busy and unaligned, output, 1 bit each: ready pulse, access in progress, and misaligned-word error pulse.

Function
REQ-015 The FSM SHALL have exactly the states IDLE and BUSY; busy = (state == BUSY).
REQ-016 In IDLE, ld_mar=1 SHALL load MAR from bus, and ld_mdr=1 SHALL load MDR from bus; while BUSY, both SHALL be ignored.
REQ-017 In IDLE with mio_en=1, ld_mar=0 and data_size=1 and MAR[0]=1, the block SHALL pulse unaligned for one cycle, stay IDLE, and issue no write.
REQ-018 In IDLE with mio_en=1, ld_mar=0 and no misalignment, the block SHALL latch r_w and data_size, load the counter with MEM_LATENCY-1, and enter BUSY.
REQ-019 In IDLE with mio_en=1 and ld_mar=1, the block SHALL load MAR only, and the access SHALL start no earlier than the next cycle.
REQ-020 In BUSY the counter SHALL decrement by 1 each cycle; r SHALL be 1 combinationally when state=BUSY and counter=0, and 0 otherwise.
REQ-021 r SHALL be asserted in the MEM_LATENCY-th cycle after the start edge, for exactly one cycle.
REQ-022 mem_we SHALL equal r AND latched r_w, giving exactly one write pulse per write access.
REQ-023 mem_mdrControl SHALL equal latched data_size while BUSY, and data_size while IDLE.
REQ-024 On the read R edge, MDR SHALL load mem_dout when word, or sign-extended mem_dout[7:0] when byte.
REQ-025 On the R edge the state SHALL return to IDLE; if mio_en is still 1 in IDLE, a new access SHALL start per REQ-017/REQ-018.
REQ-026 If mio_en drops while BUSY, the access SHALL abort: return to IDLE next edge, no r, no mem_we, MDR unchanged.
REQ-027 Counter arithmetic SHALL be 4-bit unsigned with no wrap; the counter SHALL be held at 0 in IDLE.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set state=IDLE, counter=0, MAR=0, MDR=0 and latched r_w/data_size=0, overriding all other inputs.
REQ-029 Reset asserted mid-access SHALL abort the access with no write issued, and r=0 and unaligned=0 in the following cycle.

Structure
REQ-030 The shared package lc3b_pkg SHALL hold the state encoding (IDLE=0, BUSY=1), WORD/BYTE and READ/WRITE constants, and the default MEM_LATENCY.
REQ-031 The countdown SHALL be implemented as one sub-module, mem_latency_counter (load, decrement, zero flag).

Verification
REQ-032 The bench SHALL cover word read: MAR=0x0028, mem_dout=0xF0F0, mio_en held -> r at cycle 4, MDR=0xF0F0, mem_we never 1.
REQ-033 The bench SHALL cover byte read: MAR=0x002B, mem_dout[7:0]=0x94 -> MDR=0xFF94 on R edge; and 0x14 -> MDR=0x0014.
REQ-034 The bench SHALL cover word write: MDR=0x1234, MAR=0x0030, r_w=1 -> mem_we=1 in exactly one cycle (cycle 4), mem_mdrControl=1, mem_din=0x1234.
REQ-035 The bench SHALL cover misalignment: word access with MAR=0x0031 -> unaligned=1 for one cycle, busy=0, r=0, mem_we=0.
REQ-036 The bench SHALL cover aborts: mio_en dropped at cycle 2, and separately reset at cycle 3 of a write -> no mem_we, IDLE next cycle, reset clears MAR/MDR to 0.
REQ-037 The bench SHALL cover a load while busy: ld_mar=1 with bus=0xFFFF while BUSY -> MAR unchanged; MEM_LATENCY=1 -> r in the first cycle after start.
